// File: rtl/character_draw_controller.sv
// Redraws the player sprite on the VGA adapter whenever the character FSM moves:
// erase at the last drawn position, then draw at the new one, one pixel per clock.
module character_draw_controller #(
  parameter int         SPRITE_W   = 8,
  parameter int         SPRITE_H   = 8,
  parameter int         X_ORIGIN   = 16,
  parameter int         LANE_PITCH = 40,
  parameter int         Y_POS      = 100,
  parameter logic [2:0] FG_COLOUR  = 3'b111,
  parameter logic [2:0] BG_COLOUR  = 3'b000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] CurrState,
  output logic       DoneDrawing,
  output logic [7:0] X,
  output logic [6:0] Y,
  output logic [2:0] Colour,
  output logic       Plot
);

  localparam logic [7:0] X0     = 8'(X_ORIGIN);
  localparam logic [7:0] HALF   = 8'(LANE_PITCH / 2);
  localparam logic [6:0] Y0     = 7'(Y_POS);
  localparam logic [3:0] CX_END = 4'(SPRITE_W - 1);
  localparam logic [3:0] CY_END = 4'(SPRITE_H - 1);

  typedef enum logic [2:0] {INIT, IDLE, ERASE, DRAW, DONE} state_t;

  state_t     state;
  logic [3:0] lastDrawn, target, cx, cy;
  logic [3:0] cxNext, cyNext, scanCode;
  logic       lastPix;
  logic [7:0] xNext;
  logic [6:0] yNext;

  // Base x in half-pitch units; codes 10-15 fall back to lane 0.
  function automatic logic [7:0] baseX(input logic [3:0] code);
    logic [7:0] k;
    case (code)
      4'd0:       k = 8'd0;
      4'd1:       k = 8'd2;
      4'd2:       k = 8'd4;
      4'd3:       k = 8'd6;
      4'd4, 4'd5: k = 8'd1;
      4'd6, 4'd7: k = 8'd3;
      4'd8, 4'd9: k = 8'd5;
      default:    k = 8'd0;
    endcase
    return X0 + k * HALF;
  endfunction

  always_comb begin
    lastPix  = (cx == CX_END) && (cy == CY_END);
    cxNext   = cx + 4'd1;
    cyNext   = cy;
    if (cx == CX_END) begin
      cxNext = 4'd0;
      cyNext = lastPix ? 4'd0 : cy + 4'd1;
    end
    scanCode = (state == ERASE) ? lastDrawn : target;
    xNext    = baseX(scanCode) + {4'b0, cxNext};
    yNext    = Y0 + {3'b0, cyNext};
  end

  // Outputs are loaded on the edge that enters a state, so each cycle shows its own pixel.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= INIT;
      lastDrawn   <= 4'd0;
      target      <= 4'd0;
      cx          <= 4'd0;
      cy          <= 4'd0;
      X           <= 8'd0;
      Y           <= 7'd0;
      Colour      <= BG_COLOUR;
      Plot        <= 1'b0;
      DoneDrawing <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          target      <= 4'd0;
          state       <= DRAW;
          cx          <= 4'd0;
          cy          <= 4'd0;
          X           <= baseX(4'd0);
          Y           <= Y0;
          Colour      <= FG_COLOUR;
          Plot        <= 1'b1;
          DoneDrawing <= 1'b0;
        end
        IDLE: begin
          if (CurrState != lastDrawn) begin
            target      <= CurrState;
            state       <= ERASE;
            cx          <= 4'd0;
            cy          <= 4'd0;
            X           <= baseX(lastDrawn);
            Y           <= Y0;
            Colour      <= BG_COLOUR;
            Plot        <= 1'b1;
            DoneDrawing <= 1'b0;
          end else begin
            Plot        <= 1'b0;
            DoneDrawing <= 1'b1;
          end
        end
        ERASE: begin
          if (lastPix) begin
            state  <= DRAW;
            cx     <= 4'd0;
            cy     <= 4'd0;
            X      <= baseX(target);
            Y      <= Y0;
            Colour <= FG_COLOUR;
            Plot   <= 1'b1;
          end else begin
            cx <= cxNext;
            cy <= cyNext;
            X  <= xNext;
            Y  <= yNext;
          end
        end
        DRAW: begin
          if (lastPix) begin
            state <= DONE;
            cx    <= 4'd0;
            cy    <= 4'd0;
            Plot  <= 1'b0;
          end else begin
            cx <= cxNext;
            cy <= cyNext;
            X  <= xNext;
            Y  <= yNext;
          end
        end
        DONE: begin
          lastDrawn   <= target;
          state       <= IDLE;
          DoneDrawing <= 1'b1;
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: doc/character_draw_controller.md
Name: character_draw_controller

Overview:
- Sequences redraw of the player sprite on the 160x120 VGA adapter whenever the character position FSM changes state.
- Erases the sprite at the last drawn position, then draws it at the new one, one pixel per clock.
- Holds the FSM via the DoneDrawing handshake until the redraw finishes.
- Sits between the character FSM (CurrState) and the VGA adapter (X, Y, Colour, Plot).

Parameters:
SPRITE_W, 8, sprite width in pixels (1..16)
SPRITE_H, 8, sprite height in pixels (1..16)
X_ORIGIN, 16, x of lane-0 sprite left edge
LANE_PITCH, 40, x distance between adjacent lanes (even)
Y_POS, 100, y of sprite top edge
FG_COLOUR, 3'b111, sprite colour
BG_COLOUR, 3'b000, erase colour

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
CurrState  input  4  character FSM state code (0-3 lanes, 4-9 transitions)
DoneDrawing  output  1  high = idle, FSM may advance; low = redraw in progress
X  output  8  pixel x to VGA adapter
Y  output  7  pixel y to VGA adapter
Colour  output  3  pixel colour
Plot  output  1  write strobe, one pixel per high cycle

Behaviour:
- Position map, base x by code: 0-3 -> X_ORIGIN + code*LANE_PITCH; 4,5 -> X_ORIGIN + LANE_PITCH/2; 6,7 -> X_ORIGIN + 3*LANE_PITCH/2; 8,9 -> X_ORIGIN + 5*LANE_PITCH/2; 10-15 -> treated as code 0.
- Internal regs: LastDrawn[3:0] (code currently on screen), Target[3:0], cx/cy pixel counters, FSM state.
- States:
  - INIT: entered on reset. Target <= 0, go to DRAW with no erase.
  - IDLE: DoneDrawing=1, Plot=0. If CurrState != LastDrawn: Target <= CurrState, go to ERASE. Otherwise stay.
  - ERASE: scans LastDrawn's base position with BG_COLOUR.
  - DRAW: scans Target's base position with FG_COLOUR.
  - DONE: one cycle, Plot=0, DoneDrawing=0, LastDrawn <= Target, then go to IDLE.
- Scan order: row-major, cx 0..SPRITE_W-1 inner, cy 0..SPRITE_H-1 outer; one pixel per cycle.
  - Each ERASE/DRAW cycle: Plot=1, X = base + cx, Y = Y_POS + cy, Colour per state.
  - Last pixel (cx=W-1, cy=H-1) moves ERASE->DRAW or DRAW->DONE; counters clear to 0.
- Outputs are registered and valid in the same cycle as the state they belong to. The first ERASE cycle presents pixel (base, Y_POS).
- Latency from the IDLE cycle that detects a change: 1 cycle to ERASE, then W*H ERASE cycles, W*H DRAW cycles, 1 DONE cycle. DoneDrawing is high again 2*W*H+2 cycles after the detect edge.
- DoneDrawing is low in INIT, ERASE, DRAW and DONE.
- CurrState changes while busy: ignored. They are picked up in IDLE, compared against the updated LastDrawn.
- Multiple intermediate codes skipped while busy: only the latest is drawn. No intermediate frames.
- CurrState == Target at DONE: IDLE sees no change and stays.
- Reset (async, any state): Plot=0, DoneDrawing=0, X=0, Y=0, Colour=BG_COLOUR, cx=cy=0, LastDrawn=0, state=INIT.
- On first clock after reset release: INIT -> DRAW; draws lane 0 at x 16..23, y 100..107 (defaults).
- Arithmetic: base and sums computed at 8 bits for X, 7 bits for Y. Parameters must keep X <= 159 and Y <= 119; there is no run-time clipping.

Test Plan:
- Reset release, CurrState=0 -> 64 Plot pulses FG, X 16..23, Y 100..107 row-major; DoneDrawing rises 66 cycles after release (INIT+64+DONE).
- Idle, CurrState 0->4 -> DoneDrawing low next cycle; 64 BG pixels at X 16..23, then 64 FG pixels at X 36..43, Y 100..107; DoneDrawing high after 130 cycles.
- During ERASE of 4->1, toggle CurrState 1->6->7 -> one redraw completes for 1 (X 56..63); the next IDLE starts erase of 56..63 and draw at X 76..83 for 7.
- CurrState=12 (invalid) from lane 3 -> erase X 136..143, draw X 16..23; LastDrawn=12; no further redraw while CurrState stays 12.
- Assert Reset mid-DRAW at pixel 30 -> Plot and DoneDrawing drop asynchronously before the next edge; after release, full 64-pixel INIT draw at lane 0.
- CurrState held constant for 200 cycles in IDLE -> Plot never asserts; DoneDrawing stays 1.
